// File: rtl/bus_dev_endpoint.sv
// Device-side bus endpoint: buffers host packets toward the arbiter in a TX FIFO and
// collects address-filtered arbiter deliveries in an RX FIFO.
module bus_dev_endpoint #(
   parameter int unsigned pckg_sz   = 16,
   parameter int unsigned depth     = 8,
   parameter logic [7:0]  id        = 8'h00,
   parameter logic [7:0]  broadcast = 8'hFF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tx_valid,
   input  logic [pckg_sz-1:0] tx_data,
   output logic               tx_ready,
   output logic               rx_valid,
   output logic [pckg_sz-1:0] rx_data,
   input  logic               rx_ready,
   output logic               pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   output logic [7:0]         drop_cnt,
   output logic               err_pop
);
   localparam int unsigned AW       = $clog2(depth);
   localparam logic [AW:0] PTR_STEP = {{AW{1'b0}}, 1'b1};

   logic [pckg_sz-1:0] txMem_q [depth];
   logic [pckg_sz-1:0] rxMem_q [depth];
   logic [AW:0]        txWrPtr_q, txWrPtr_d, txRdPtr_q, txRdPtr_d;
   logic [AW:0]        rxWrPtr_q, rxWrPtr_d, rxRdPtr_q, rxRdPtr_d;
   logic [7:0]         dropCnt_q, dropCnt_d;
   logic               errPop_q, errPop_d;

   logic txEmpty, txFull, rxEmpty, rxFull;
   logic txWrEn, txRdEn, rxMatch, rxWrEn, rxRdEn, rxDrop;

   // The pointer MSB is a wrap bit: equal low bits with differing MSBs means full.
   assign txEmpty = (txWrPtr_q == txRdPtr_q);
   assign txFull  = (txWrPtr_q[AW] != txRdPtr_q[AW]) &&
                    (txWrPtr_q[AW-1:0] == txRdPtr_q[AW-1:0]);
   assign rxEmpty = (rxWrPtr_q == rxRdPtr_q);
   assign rxFull  = (rxWrPtr_q[AW] != rxRdPtr_q[AW]) &&
                    (rxWrPtr_q[AW-1:0] == rxRdPtr_q[AW-1:0]);

   assign txWrEn  = tx_valid && !txFull;
   assign txRdEn  = pop && !txEmpty;
   assign rxMatch = push && ((D_push[pckg_sz-1 -: 8] == id) ||
                             (D_push[pckg_sz-1 -: 8] == broadcast));
   assign rxWrEn  = rxMatch && !rxFull;
   assign rxDrop  = rxMatch && rxFull;
   assign rxRdEn  = rx_ready && !rxEmpty;

   assign tx_ready = !txFull;
   assign pndng    = !txEmpty;
   assign D_pop    = txEmpty ? '0 : txMem_q[txRdPtr_q[AW-1:0]];
   assign rx_valid = !rxEmpty;
   assign rx_data  = rxEmpty ? '0 : rxMem_q[rxRdPtr_q[AW-1:0]];
   assign drop_cnt = dropCnt_q;
   assign err_pop  = errPop_q;

   always_comb begin
      txWrPtr_d = txWrEn ? txWrPtr_q + PTR_STEP : txWrPtr_q;
      txRdPtr_d = txRdEn ? txRdPtr_q + PTR_STEP : txRdPtr_q;
      rxWrPtr_d = rxWrEn ? rxWrPtr_q + PTR_STEP : rxWrPtr_q;
      rxRdPtr_d = rxRdEn ? rxRdPtr_q + PTR_STEP : rxRdPtr_q;
      dropCnt_d = (rxDrop && (dropCnt_q != 8'hFF)) ? dropCnt_q + 8'd1 : dropCnt_q;
      errPop_d  = errPop_q || (pop && txEmpty);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txWrPtr_q <= '0;
         txRdPtr_q <= '0;
         rxWrPtr_q <= '0;
         rxRdPtr_q <= '0;
         dropCnt_q <= '0;
         errPop_q  <= 1'b0;
      end else begin
         txWrPtr_q <= txWrPtr_d;
         txRdPtr_q <= txRdPtr_d;
         rxWrPtr_q <= rxWrPtr_d;
         rxRdPtr_q <= rxRdPtr_d;
         dropCnt_q <= dropCnt_d;
         errPop_q  <= errPop_d;
      end
   end

   // Storage needs no reset: every output read of it is masked while its FIFO is empty.
   always_ff @(posedge clk) begin
      if (txWrEn) txMem_q[txWrPtr_q[AW-1:0]] <= tx_data;
      if (rxWrEn) rxMem_q[rxWrPtr_q[AW-1:0]] <= D_push;
   end
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Scoreboard bench for bus_dev_endpoint: directed scenarios plus random traffic, checked
// against a queue-based reference model of the two FIFOs.
module tb_bus_dev_endpoint;
   localparam int         PckgSz = 16;
   localparam int         Depth  = 4;
   localparam logic [7:0] DevId  = 8'h02;
   localparam logic [7:0] Bcast  = 8'hFF;

   logic              clk;
   logic              reset;
   logic              txValid;
   logic [PckgSz-1:0] txData;
   logic              txReady;
   logic              rxValid;
   logic [PckgSz-1:0] rxData;
   logic              rxReady;
   logic              pndng;
   logic [PckgSz-1:0] dPop;
   logic              pop;
   logic              push;
   logic [PckgSz-1:0] dPush;
   logic [7:0]        dropCnt;
   logic              errPop;

   int checks = 0;
   int errors = 0;

   logic [15:0] txModel[$];
   logic [15:0] rxModel[$];
   logic [15:0] txExp[$];
   logic [15:0] rxExp[$];
   int          dropModel;
   bit          errModel;
   bit          txWr, txRd, rxHit, rxWr, rxRd;
   logic [15:0] expWord;

   bus_dev_endpoint #(
      .pckg_sz(PckgSz), .depth(Depth), .id(DevId), .broadcast(Bcast)
   ) dut (
      .clk(clk), .reset(reset),
      .tx_valid(txValid), .tx_data(txData), .tx_ready(txReady),
      .rx_valid(rxValid), .rx_data(rxData), .rx_ready(rxReady),
      .pndng(pndng), .D_pop(dPop), .pop(pop),
      .push(push), .D_push(dPush),
      .drop_cnt(dropCnt), .err_pop(errPop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the endpoint seen as two bounded queues, updated from the
   // inputs presented at each rising edge. Accepted packets go to the scoreboard.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         txModel.delete();
         rxModel.delete();
         txExp.delete();
         rxExp.delete();
         dropModel = 0;
         errModel  = 1'b0;
      end else begin
         txWr  = txValid && (txModel.size() < Depth);
         txRd  = pop && (txModel.size() > 0);
         if (pop && txModel.size() == 0) errModel = 1'b1;
         rxHit = push && ((dPush[15:8] == DevId) || (dPush[15:8] == Bcast));
         rxWr  = rxHit && (rxModel.size() < Depth);
         if (rxHit && !rxWr && dropModel < 255) dropModel = dropModel + 1;
         rxRd  = rxReady && (rxModel.size() > 0);
         if (txRd) void'(txModel.pop_front());
         if (txWr) begin
            txModel.push_back(txData);
            txExp.push_back(txData);
         end
         if (rxRd) void'(rxModel.pop_front());
         if (rxWr) begin
            rxModel.push_back(dPush);
            rxExp.push_back(dPush);
         end
      end
   end

   // Monitor: on the falling edge compare status outputs with the model and, whenever
   // the DUT presents a handshake, pop the scoreboard and compare the data word.
   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("pndng", 32'(pndng), 32'(txModel.size() > 0));
         checkOutput("tx_ready", 32'(txReady), 32'(txModel.size() < Depth));
         checkOutput("rx_valid", 32'(rxValid), 32'(rxModel.size() > 0));
         checkOutput("drop_cnt", 32'(dropCnt), 32'(dropModel));
         checkOutput("err_pop", 32'(errPop), 32'(errModel));
         if (!pndng) checkOutput("D_pop_empty", 32'(dPop), 32'h0);
         if (!rxValid) checkOutput("rx_data_empty", 32'(rxData), 32'h0);
         if (pndng && pop) begin
            if (txExp.size() > 0) begin
               expWord = txExp.pop_front();
               checkOutput("D_pop", 32'(dPop), 32'(expWord));
            end else begin
               checks++;
               errors++;
               $display("[TB] FAIL D_pop: got %0h, expected no packet", dPop);
            end
         end
         if (rxValid && rxReady) begin
            if (rxExp.size() > 0) begin
               expWord = rxExp.pop_front();
               checkOutput("rx_data", 32'(rxData), 32'(expWord));
            end else begin
               checks++;
               errors++;
               $display("[TB] FAIL rx_data: got %0h, expected no packet", rxData);
            end
         end
      end
   end

   task automatic applyStimulus(input logic tv, input logic [15:0] td, input logic p,
                                input logic pu, input logic [15:0] pd, input logic rr);
      @(posedge clk);
      #1;
      txValid = tv;
      txData  = td;
      pop     = p;
      push    = pu;
      dPush   = pd;
      rxReady = rr;
   endtask

   task automatic checkResetState();
      checkOutput("rst_pndng", 32'(pndng), 32'h0);
      checkOutput("rst_D_pop", 32'(dPop), 32'h0);
      checkOutput("rst_tx_ready", 32'(txReady), 32'h1);
      checkOutput("rst_rx_valid", 32'(rxValid), 32'h0);
      checkOutput("rst_rx_data", 32'(rxData), 32'h0);
      checkOutput("rst_drop_cnt", 32'(dropCnt), 32'h0);
      checkOutput("rst_err_pop", 32'(errPop), 32'h0);
   endtask

   // Reset pulses for 3 ns between edges; outputs must clear without any clock edge.
   task automatic applyReset();
      @(posedge clk);
      #1;
      txValid = 1'b0;
      pop     = 1'b0;
      push    = 1'b0;
      rxReady = 1'b0;
      reset   = 1'b1;
      #1;
      checkResetState();
      #2;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] addr;
      int         sel;
      reset   = 1'b1;
      txValid = 1'b0;
      txData  = '0;
      pop     = 1'b0;
      push    = 1'b0;
      dPush   = '0;
      rxReady = 1'b0;
      #11;
      checkResetState();
      #1;
      reset = 1'b0;

      $display("[TB] TX ordering and full");
      for (int i = 0; i < 5; i++) applyStimulus(1, 16'(16'h0301 + i * 16'h0101), 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] Simultaneous write and pop");
      for (int i = 0; i < 4; i++) applyStimulus(1, 16'(16'h1100 + i), 0, 0, 0, 0);
      applyStimulus(1, 16'h0A0A, 1, 0, 0, 0);
      applyStimulus(1, 16'h0B0B, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] RX address filter");
      applyStimulus(0, 0, 0, 1, 16'h02AA, 0);
      applyStimulus(0, 0, 0, 1, 16'h05BB, 0);
      applyStimulus(0, 0, 0, 1, 16'hFFCC, 0);
      for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] RX overflow and saturation");
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 16'(16'h0210 + i), 0);
      for (int i = 0; i < 300; i++) applyStimulus(0, 0, 0, 1, 16'(16'hFF00 + (i % 256)), 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] Pop on empty");
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(1, 16'h0299, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] Reset mid-operation");
      applyStimulus(1, 16'h0301, 0, 1, 16'h0211, 0);
      applyStimulus(1, 16'h0302, 0, 1, 16'hFF22, 0);
      applyStimulus(1, 16'h0303, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyReset();

      $display("[TB] Random traffic");
      for (int i = 0; i < 2000; i++) begin
         sel = int'($urandom_range(0, 2));
         addr = (sel == 0) ? DevId : (sel == 1) ? Bcast : 8'($urandom);
         applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), {addr, 8'($urandom)}, 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < Depth + 2; i++) applyStimulus(0, 0, 1, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("tx_leftover", 32'(txExp.size()), 32'h0);
      checkOutput("rx_leftover", 32'(rxExp.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bus_dev_endpoint.md
# bus_dev_endpoint

Device-side endpoint for the shared bus generator/arbiter: one instance per device position (`drvrs` instances per bus). It buffers packets from a local host into a TX FIFO, presents them to the arbiter through the `pndng`/`pop`/`D_pop` handshake, and accepts arbiter deliveries on `push`/`D_push` into an RX FIFO, filtered by destination address. It is the synthesizable counterpart of the bench driver's FIFO model.

## Interface
- `pckg_sz`, default 16: packet width in bits; the top 8 bits are the destination ID.
- `depth`, default 8: entries per FIFO; must be a power of two, ≥ 2.
- `id`, default 0: 8-bit address of this device.
- `broadcast`, default 8'hFF: destination ID accepted by every device.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `tx_valid` input 1: host offers `tx_data` for transmission.
- `tx_data` input pckg_sz: packet to transmit.
- `tx_ready` output 1: TX FIFO not full.
- `rx_valid` output 1: RX FIFO not empty.
- `rx_data` output pckg_sz: head of RX FIFO.
- `rx_ready` input 1: host consumes the RX head.
- `pndng` output 1: TX FIFO not empty (to arbiter).
- `D_pop` output pckg_sz: head of TX FIFO (to arbiter).
- `pop` input 1: arbiter consumes the TX head.
- `push` input 1: arbiter delivers `D_push`.
- `D_push` input pckg_sz: delivered packet.
- `drop_cnt` output 8: saturating count of RX packets dropped because the FIFO was full.
- `err_pop` output 1: sticky flag, set when `pop` arrives with `pndng` low.

## Operation
- TX FIFO: circular buffer with read and write pointers of log2(depth)+1 bits; the MSB distinguishes full from empty. Pointers wrap modulo 2·depth.
- TX write: occurs when `tx_valid && tx_ready`. `tx_ready = !tx_full`. It does not depend on `pop` in the same cycle, so a full FIFO refuses the write even while a pop is in flight.
- TX read: occurs when `pop && pndng`, and advances the read pointer. `pop` while `pndng = 0` changes no pointer and sets `err_pop`.
- `D_pop` and `pndng` are driven combinationally from the FIFO head and the empty flag. `D_pop` reads 0 when the FIFO is empty.
- RX accept condition: `push` is high and `D_push[pckg_sz-1 -: 8]` equals `id` or `broadcast`.
  - Accepted, FIFO not full: write.
  - Accepted, FIFO full: discard the packet and increment `drop_cnt`, saturating at 255.
  - Address mismatch: ignore silently; no count.
- RX full uses the pre-edge state. A simultaneous host read (`rx_valid && rx_ready`) does not make room for a push in that same cycle.
- RX read: occurs when `rx_valid && rx_ready`. `rx_data` is combinational from the head and reads 0 when the FIFO is empty.
- Packets are stored unmodified, including the address byte.

## Timing
- Reset values: both FIFOs empty, `pndng = 0`, `D_pop = 0`, `tx_ready = 1`, `rx_valid = 0`, `rx_data = 0`, `drop_cnt = 0`, `err_pop = 0`.
- Reset asserted mid-transfer discards all buffered packets immediately, with no edge needed.
- Write-to-visible latency is one cycle in each direction:
  - TX: a write at edge N raises `pndng` after edge N on an empty FIFO.
  - RX: a push at edge N raises `rx_valid` after edge N.
- Pop: sampled at edge N. `D_pop` shows the next entry, or 0 with `pndng` low, after edge N. Back-to-back pops drain one entry per cycle.
- Simultaneous TX write and pop on a non-full, non-empty FIFO: both take effect and the occupancy is unchanged.
- Simultaneous TX write and pop on an empty FIFO: the pop sets `err_pop` and the write still lands.
- Simultaneous RX push and read on a non-full FIFO: both take effect.

## Test plan
Configuration for all scenarios: `pckg_sz = 16`, `depth = 4`, `id = 8'h02`.

- **Reset mid-operation.** Load 3 TX and 2 RX packets, assert `reset` for 3 ns between edges → all outputs return to reset values immediately; `pndng = 0`, `rx_valid = 0`.
- **TX ordering and full.** Write 16'h0301, 16'h0402, 16'h0503, 16'h0604, then offer 16'h0705 → `tx_ready = 0` after the 4th write, and the 5th is not stored. Pops one per cycle yield `D_pop` = 0301, 0402, 0503, 0604, then `pndng = 0`.
- **Simultaneous write and pop.** With 4 entries stored, assert `pop` and `tx_valid` together → the pop succeeds and the write is refused. On the next cycle, pop plus write on 3 entries → occupancy stays 3.
- **RX address filter.** Push 16'h02AA, 16'h05BB, 16'hFFCC → `rx_data` sequence is 02AA, FFCC; 05BB is absent; `drop_cnt = 0`.
- **RX overflow.** Fill the RX FIFO with 4 matching packets, push 2 more → `drop_cnt = 2`, and the FIFO contents are the first 4 in order. Then 300 further drops → `drop_cnt = 255`.
- **Pop on empty.** Assert `pop` with `pndng = 0` → `err_pop = 1` and stays set until `reset`; TX pointers are unchanged (a following write and pop returns the written packet).
